verificador_contador: RTL and testbench

- Synthesizable cycle-by-cycle checker for the 16-bit, 4-mode counter with RCO.
- Sits on the counter interface in parallel with the DUT and observes the same CLK, ENB, MODO, entrada, salida and RCO that the stimulus generator drives and the counter returns.
- Predicts the next salida/RCO from the previously observed state and command, then flags mismatches.
- Keeps error and check statistics for the bench or for an on-chip status register.

---
 rtl/verificador_contador_pkg.sv | 26 ++
 rtl/verificador_contador_if.sv | 19 +
 rtl/modelo_contador.sv | 55 +++++
 rtl/verificador_contador.sv | 106 ++++++++++
 tb/tb_verificador_contador.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/verificador_contador_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : verificador_contador_pkg
//  Description : Shared mode/state encodings and default sizes for the
//                counter checker.
//  Revision    : 1.0 - initial release
// ============================================================================
package verificador_contador_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int PASO_DEF  = 3;
    localparam int CNT_W_DEF = 16;

    localparam logic [1:0] MODO_SUBE  = 2'b00;
    localparam logic [1:0] MODO_BAJA  = 2'b01;
    localparam logic [1:0] MODO_BAJA3 = 2'b10;
    localparam logic [1:0] MODO_CARGA = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_CHECK = 2'b01,
        ST_FALLA = 2'b10
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/verificador_contador_if.sv
`default_nettype none
// ============================================================================
//  Module      : verificador_contador_if
//  Description : Counter bus as seen by stimulus generator and checker.
//  Revision    : 1.0 - initial release
// ============================================================================
interface verificador_contador_if #(
    parameter int WIDTH = verificador_contador_pkg::WIDTH_DEF
);
    logic             ENB;
    logic [1:0]       MODO;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] salida;
    logic             RCO;

    modport master (output ENB, MODO, entrada, salida, RCO);
    modport slave  (input  ENB, MODO, entrada, salida, RCO);
endinterface
`default_nettype wire

// File: rtl/modelo_contador.sv
`default_nettype none
// ============================================================================
//  Module      : modelo_contador
//  Description : Combinational next-count / next-RCO predictor of the
//                4-mode counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module modelo_contador
    import verificador_contador_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int PASO_BAJADA = PASO_DEF
) (
    input  wire logic             i_enb,
    input  wire logic [1:0]       i_modo,
    input  wire logic [WIDTH-1:0] i_entrada,
    input  wire logic [WIDTH-1:0] i_salida,
    output logic      [WIDTH-1:0] o_siguiente,
    output logic                  o_rco
);

    localparam logic [WIDTH-1:0] c_uno  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_paso = WIDTH'(PASO_BAJADA);

    logic [WIDTH:0] w_resta;

    always_comb begin
        o_siguiente = i_salida;
        o_rco       = 1'b0;
        // Extra MSB carries the borrow of the step-down subtraction.
        w_resta     = {1'b0, i_salida} - {1'b0, c_paso};
        if (i_enb) begin
            case (i_modo)
                MODO_SUBE: begin
                    o_siguiente = i_salida + c_uno;
                    o_rco       = &i_salida;
                end
                MODO_BAJA: begin
                    o_siguiente = i_salida - c_uno;
                    o_rco       = (i_salida == '0);
                end
                MODO_BAJA3: begin
                    o_siguiente = w_resta[WIDTH-1:0];
                    o_rco       = w_resta[WIDTH];
                end
                default: begin
                    o_siguiente = i_entrada;
                    o_rco       = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/verificador_contador.sv
`default_nettype none
// ============================================================================
//  Module      : verificador_contador
//  Description : Cycle-by-cycle checker of the 4-mode counter with RCO.
//  Revision    : 1.0 - initial release
// ============================================================================
module verificador_contador
    import verificador_contador_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEF,
    parameter int PASO_BAJADA = PASO_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  wire logic              CLK,
    input  wire logic              RESET,
    verificador_contador_if.slave  bus,
    input  wire logic              clr_err,
    output logic                   error,
    output logic                   error_sticky,
    output logic [CNT_W-1:0]       err_count,
    output logic [CNT_W-1:0]       check_count,
    output logic [WIDTH-1:0]       esperado,
    output logic [1:0]             estado
);

    localparam logic [CNT_W-1:0] c_cnt_uno = CNT_W'(1);

    estado_t          r_estado, w_estado_sig;
    logic             r_hist_enb;
    logic [1:0]       r_hist_modo;
    logic [WIDTH-1:0] r_hist_entrada, r_hist_salida;
    logic [WIDTH-1:0] w_pred;
    logic             w_pred_rco, w_compara, w_falla;
    logic             r_error, r_sticky;
    logic [CNT_W-1:0] r_err_count, r_check_count;

    modelo_contador #(
        .WIDTH       (WIDTH),
        .PASO_BAJADA (PASO_BAJADA)
    ) u_modelo (
        .i_enb       (r_hist_enb),
        .i_modo      (r_hist_modo),
        .i_entrada   (r_hist_entrada),
        .i_salida    (r_hist_salida),
        .o_siguiente (w_pred),
        .o_rco       (w_pred_rco)
    );

    // History is only meaningful once one post-reset edge has been captured.
    assign w_compara = (r_estado != ST_INIT);
    assign w_falla   = w_compara &&
                       ((bus.salida != w_pred) || (bus.RCO != w_pred_rco));

    always_ff @(posedge CLK) begin
        if (RESET) r_estado <= ST_INIT;
        else       r_estado <= w_estado_sig;
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            ST_INIT:  w_estado_sig = ST_CHECK;
            ST_CHECK: if (w_falla && !clr_err) w_estado_sig = ST_FALLA;
            ST_FALLA: if (clr_err) w_estado_sig = ST_CHECK;
            default:  w_estado_sig = ST_INIT;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_hist_enb     <= 1'b0;
            r_hist_modo    <= 2'b00;
            r_hist_entrada <= '0;
            r_hist_salida  <= '0;
            r_error        <= 1'b0;
            r_sticky       <= 1'b0;
            r_err_count    <= '0;
            r_check_count  <= '0;
        end else begin
            // Always resynchronise on the observed output, never on the prediction.
            r_hist_enb     <= bus.ENB;
            r_hist_modo    <= bus.MODO;
            r_hist_entrada <= bus.entrada;
            r_hist_salida  <= bus.salida;
            r_error        <= w_falla;
            if (clr_err) begin
                r_sticky    <= 1'b0;
                r_err_count <= '0;
            end else if (w_falla) begin
                r_sticky <= 1'b1;
                if (r_err_count != '1) r_err_count <= r_err_count + c_cnt_uno;
            end
            if (w_compara && (r_check_count != '1))
                r_check_count <= r_check_count + c_cnt_uno;
        end
    end

    assign error        = r_error;
    assign error_sticky = r_sticky;
    assign err_count    = r_err_count;
    assign check_count  = r_check_count;
    assign esperado     = w_compara ? w_pred : '0;
    assign estado       = r_estado;

endmodule
`default_nettype wire

// File: tb/tb_verificador_contador.sv
`default_nettype none
// ============================================================================
//  Module      : tb_verificador_contador
//  Description : Self-checking bench: emulated counter with fault injection
//                drives the bus; outputs checked against an integer model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_verificador_contador;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk, rst, clr_err;
    logic          error, error_sticky;
    logic [CW-1:0] err_count, check_count;
    logic [15:0]   esperado;
    logic [1:0]    estado;

    verificador_contador_if #(.WIDTH(16)) bus ();

    verificador_contador #(.WIDTH(16), .PASO_BAJADA(3), .CNT_W(CW)) dut (
        .CLK          (clk),
        .RESET        (rst),
        .bus          (bus),
        .clr_err      (clr_err),
        .error        (error),
        .error_sticky (error_sticky),
        .err_count    (err_count),
        .check_count  (check_count),
        .esperado     (esperado),
        .estado       (estado)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;

    // Reference state: integers only.
    int m_st, m_ec, m_cc, m_err, m_sticky, m_esp;
    int h_enb, h_modo, h_ent, h_sal;
    int cnt_val, cnt_rco;

    task automatic chk(input string nombre, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nombre, act, exp);
        end
    endtask

    // Returns next value + 65536*rco of a correct 16-bit counter.
    function automatic int calc(int enb, int modo, int ent, int sal);
        int v, c;
        v = sal;
        c = 0;
        if (enb != 0) begin
            case (modo)
                0:       begin v = sal + 1; c = (sal == 65535) ? 1 : 0; end
                1:       begin v = sal - 1; c = (sal == 0) ? 1 : 0; end
                2:       begin v = sal - 3; c = (sal < 3) ? 1 : 0; end
                default: v = ent;
            endcase
        end
        return ((v + 65536) % 65536) + 65536 * c;
    endfunction

    task automatic ciclo(input logic enb, input logic [1:0] modo, input logic [15:0] ent,
                         input logic [15:0] xsal, input logic xrco, input logic clr, input logic r);
        int sal_d, rco_d, p, mis;
        @(negedge clk);
        sal_d       = cnt_val ^ int'(xsal);
        rco_d       = cnt_rco ^ (xrco ? 1 : 0);
        bus.ENB     = enb;
        bus.MODO    = modo;
        bus.entrada = ent;
        bus.salida  = 16'(sal_d);
        bus.RCO     = (rco_d != 0);
        clr_err     = clr;
        rst         = r;
        @(posedge clk);
        if (r) begin
            m_st = 0; m_ec = 0; m_cc = 0; m_err = 0; m_sticky = 0; m_esp = 0;
            h_enb = 0; h_modo = 0; h_ent = 0; h_sal = 0;
            cnt_val = 0; cnt_rco = 0;
        end else begin
            p   = calc(h_enb, h_modo, h_ent, h_sal);
            mis = (m_st != 0 && (sal_d != p % 65536 || rco_d != p / 65536)) ? 1 : 0;
            m_err = mis;
            if (clr) begin
                m_sticky = 0; m_ec = 0;
            end else if (mis != 0) begin
                m_sticky = 1;
                if (m_ec < CMAX) m_ec++;
            end
            if (m_st != 0 && m_cc < CMAX) m_cc++;
            if (m_st == 0 || clr) m_st = 1;
            else if (mis != 0)    m_st = 2;
            h_enb = enb ? 1 : 0; h_modo = int'(modo); h_ent = int'(ent); h_sal = sal_d;
            p       = calc(h_enb, h_modo, h_ent, h_sal);
            cnt_val = p % 65536;
            cnt_rco = p / 65536;
            m_esp   = cnt_val;
        end
        #1;
        chk("error",        32'(error),        32'(m_err));
        chk("error_sticky", 32'(error_sticky), 32'(m_sticky));
        chk("err_count",    32'(err_count),    32'(m_ec));
        chk("check_count",  32'(check_count),  32'(m_cc));
        chk("esperado",     32'(esperado),     32'(m_esp));
        chk("estado",       32'(estado),       32'(m_st));
    endtask

    typedef struct {
        logic        enb;
        logic [1:0]  modo;
        logic [15:0] ent;
        logic [15:0] xsal;
        logic        xrco;
        logic        clr;
        logic        e_err;
        logic        e_sticky;
        int          e_ec;
        int          e_cc;
        logic [1:0]  e_st;
        logic [15:0] e_esp;
    } vec_t;

    vec_t tabla[12];

    initial begin
        // enb modo ent xsal xrco clr | err sticky ec cc st esperado
        tabla[0]  = '{1'b1, 2'd3, 16'h0004, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0,  2'd1, 16'h0004};
        tabla[1]  = '{1'b1, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1,  2'd1, 16'h0001};
        tabla[2]  = '{1'b1, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 2,  2'd1, 16'hFFFE};
        tabla[3]  = '{1'b1, 2'd2, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1, 3,  2'd2, 16'hFFFC};
        tabla[4]  = '{1'b1, 2'd2, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4,  2'd2, 16'hFFF9};
        tabla[5]  = '{1'b0, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 1, 5,  2'd2, 16'hFFF9};
        tabla[6]  = '{1'b0, 2'd0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 2, 6,  2'd2, 16'hFFF8};
        tabla[7]  = '{1'b1, 2'd3, 16'h00AA, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 2, 7,  2'd2, 16'h00AA};
        tabla[8]  = '{1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 8,  2'd1, 16'h00AB};
        tabla[9]  = '{1'b1, 2'd3, 16'h00AA, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1, 9,  2'd2, 16'h00AA};
        tabla[10] = '{1'b1, 2'd0, 16'h0000, 16'h0100, 1'b0, 1'b1, 1'b1, 1'b0, 0, 10, 2'd1, 16'h01AB};
        tabla[11] = '{1'b1, 2'd1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 11, 2'd1, 16'h01AA};

        rst = 1'b1; clr_err = 1'b0;
        bus.ENB = 1'b0; bus.MODO = 2'b00; bus.entrada = '0; bus.salida = '0; bus.RCO = 1'b0;
        cnt_val = 0; cnt_rco = 0;
        h_enb = 0; h_modo = 0; h_ent = 0; h_sal = 0;
        m_st = 0; m_ec = 0; m_cc = 0; m_err = 0; m_sticky = 0; m_esp = 0;

        ciclo(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
        ciclo(1'b0, 2'd0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            ciclo(tabla[i].enb, tabla[i].modo, tabla[i].ent, tabla[i].xsal,
                  tabla[i].xrco, tabla[i].clr, 1'b0);
            chk($sformatf("tbl%0d_error", i),    32'(error),        32'(tabla[i].e_err));
            chk($sformatf("tbl%0d_sticky", i),   32'(error_sticky), 32'(tabla[i].e_sticky));
            chk($sformatf("tbl%0d_errcnt", i),   32'(err_count),    32'(tabla[i].e_ec));
            chk($sformatf("tbl%0d_chkcnt", i),   32'(check_count),  32'(tabla[i].e_cc));
            chk($sformatf("tbl%0d_estado", i),   32'(estado),       32'(tabla[i].e_st));
            chk($sformatf("tbl%0d_esperado", i), 32'(esperado),     32'(tabla[i].e_esp));
        end

        // Up-count wrap with RCO.
        ciclo(1'b1, 2'd3, 16'hFFFE, 16'h0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_sube_esperado", 32'(esperado), 32'h0000);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_sube_error", 32'(error), 32'd0);

        // Down-count wrap with RCO.
        ciclo(1'b1, 2'd3, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd1, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd1, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_baja_esperado", 32'(esperado), 32'hFFFF);
        ciclo(1'b1, 2'd1, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("wrap_baja_error", 32'(error), 32'd0);

        // Missing RCO on the up-count wrap.
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("rco_perdido_error",  32'(error),  32'd1);
        chk("rco_perdido_estado", 32'(estado), 32'd2);

        // Reset while in FALLA; no compare on the first edge after release.
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_error",    32'(error),        32'd0);
        chk("rst_sticky",   32'(error_sticky), 32'd0);
        chk("rst_errcnt",   32'(err_count),    32'd0);
        chk("rst_chkcnt",   32'(check_count),  32'd0);
        chk("rst_esperado", 32'(esperado),     32'd0);
        chk("rst_estado",   32'(estado),       32'd0);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0F0F, 1'b0, 1'b0, 1'b0);
        chk("post_rst1_chkcnt", 32'(check_count), 32'd0);
        chk("post_rst1_error",  32'(error),       32'd0);
        chk("post_rst1_estado", 32'(estado),      32'd1);
        ciclo(1'b1, 2'd0, 16'h0000, 16'h0, 1'b0, 1'b0, 1'b0);
        chk("post_rst2_chkcnt", 32'(check_count), 32'd1);
        chk("post_rst2_error",  32'(error),       32'd0);
        chk("post_rst2_estado", 32'(estado),      32'd1);

        // Counter saturation.
        for (int i = 0; i < 20; i++)
            ciclo(1'b1, 2'd0, 16'h0000, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk("sat_errcnt", 32'(err_count),   32'(CMAX));
        chk("sat_chkcnt", 32'(check_count), 32'(CMAX));
        chk("sat_estado", 32'(estado),      32'd2);

        // Randomised traffic with boundary-biased load values.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] ent, xs;
            int sel;
            sel = int'($urandom_range(0, 5));
            case (sel)
                0:       ent = 16'h0000;
                1:       ent = 16'h0001;
                2:       ent = 16'h0002;
                3:       ent = 16'hFFFF;
                4:       ent = 16'hFFFE;
                default: ent = 16'($urandom);
            endcase
            xs = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
            ciclo($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), ent, xs,
                  $urandom_range(0, 14) == 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 49) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
